core_clock_monitor: RTL

//  Parametrised successor to the SoC clock divider and PC progress LEDs. Generates the core clock from the board clock

---
 rtl/core_clock_monitor.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/core_clock_monitor.sv
// core_clock_monitor
// Divides the board clock down to the core clock with run / pause / single-step
// control, samples the core program counter once per core period, detects a
// stalled PC, and drives an NLED-wide progress display (dot, bar, raw, blank)
// that blinks while the core is considered halted.
module core_clock_monitor #(
    parameter int CLK_RATE    = 50_000_000,
    parameter int CORE_RATE   = 6_250_000,
    parameter int WIDTH       = 32,
    parameter int ROM_DEPTH   = 2500,
    parameter int NLED        = 10,
    parameter int HALT_CYCLES = 1024,
    parameter int BLINK_HZ    = 2
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             run,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pc,
    output logic             clk_core,
    output logic             core_tick,
    output logic             halted,
    output logic [NLED-1:0]  led
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int CORE_MAX  = CLK_RATE / CORE_RATE / 2 - 1;
    localparam int BLINK_MAX = CLK_RATE / (2 * BLINK_HZ) - 1;
    localparam int CNT_W     = (CORE_MAX > 0) ? $clog2(CORE_MAX + 1) : 1;
    localparam int BLINK_W   = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;
    localparam int HALT_W    = (HALT_CYCLES > 0) ? $clog2(HALT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]   CORE_MAX_C  = CNT_W'(CORE_MAX);
    localparam logic [BLINK_W-1:0] BLINK_MAX_C = BLINK_W'(BLINK_MAX);
    localparam logic [HALT_W-1:0]  HALT_MAX_C  = HALT_W'(HALT_CYCLES);

    localparam logic [1:0] MODE_DOT = 2'b00;
    localparam logic [1:0] MODE_BAR = 2'b01;
    localparam logic [1:0] MODE_RAW = 2'b10;

    // Reject parameter sets that cannot produce a valid divider or display
    if (CORE_MAX < 0) begin : g_bad_core_rate
        $error("core_clock_monitor: CORE_RATE too high for CLK_RATE (CORE_MAX < 0)");
    end
    if (BLINK_MAX < 0) begin : g_bad_blink_rate
        $error("core_clock_monitor: BLINK_HZ too high for CLK_RATE");
    end
    if (NLED < 2) begin : g_bad_nled
        $error("core_clock_monitor: NLED must be at least 2");
    end
    if (HALT_CYCLES < 1) begin : g_bad_halt
        $error("core_clock_monitor: HALT_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Core clock divider and single-step control
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             clk_core_reg, clk_core_next;
    logic             stepping_reg, stepping_next;
    logic             core_tick_reg, core_tick_next;

    logic enabled;
    logic at_max;
    logic rise_evt;
    logic fall_evt;
    logic step_accept;

    // Divider qualifiers: keeping clk_core in the enable guarantees a started
    // high phase always runs to completion, so the clock only parks low.
    always_comb begin
        enabled     = run | stepping_reg | clk_core_reg;
        at_max      = (cnt_reg == CORE_MAX_C);
        rise_evt    = enabled & at_max & ~clk_core_reg;
        fall_evt    = enabled & at_max & clk_core_reg;
        step_accept = step & ~run & ~clk_core_reg & ~stepping_reg;
    end

    // Divider next state: count while enabled, park with cnt=0 when idle
    always_comb begin
        cnt_next       = cnt_reg;
        clk_core_next  = clk_core_reg;
        stepping_next  = stepping_reg;
        core_tick_next = rise_evt;

        if (!enabled) begin
            cnt_next = '0;
        end else if (at_max) begin
            cnt_next      = '0;
            clk_core_next = ~clk_core_reg;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end

        // A step owns exactly one full period; it ends on the falling edge.
        if (step_accept) begin
            stepping_next = 1'b1;
        end else if (fall_evt) begin
            stepping_next = 1'b0;
        end
    end

    // Divider registers; an async reset mid-step drops the pending step
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cnt_reg       <= '0;
            clk_core_reg  <= 1'b0;
            stepping_reg  <= 1'b0;
            core_tick_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            clk_core_reg  <= clk_core_next;
            stepping_reg  <= stepping_next;
            core_tick_reg <= core_tick_next;
        end
    end

    // ------------------------------------------------------------------
    // PC sampling and halt detection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  pc_q_reg, pc_q_next;
    logic [HALT_W-1:0] halt_cnt_reg, halt_cnt_next;
    logic              halted_reg, halted_next;

    // Sample on the core-clock fall, when the core's PC has long settled;
    // count consecutive unchanged samples up to the halt threshold.
    always_comb begin
        pc_q_next     = pc_q_reg;
        halt_cnt_next = halt_cnt_reg;
        halted_next   = (halt_cnt_reg == HALT_MAX_C);

        if (fall_evt) begin
            pc_q_next = pc;
            if (pc == pc_q_reg) begin
                if (halt_cnt_reg != HALT_MAX_C) begin
                    halt_cnt_next = halt_cnt_reg + 1'b1;
                end
            end else begin
                halt_cnt_next = '0;
            end
        end
    end

    // Sampled PC and halt state registers
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pc_q_reg     <= '0;
            halt_cnt_reg <= '0;
            halted_reg   <= 1'b0;
        end else begin
            pc_q_reg     <= pc_q_next;
            halt_cnt_reg <= halt_cnt_next;
            halted_reg   <= halted_next;
        end
    end

    // ------------------------------------------------------------------
    // Progress index and LED patterns
    // ------------------------------------------------------------------
    // ge[k] = (pc_q >= k*ROM_DEPTH/NLED). Thresholds are non-decreasing in k,
    // so the set of true bits is always a contiguous run starting at k=0 and
    // the progress index i equals the highest k with ge[k] set. ge[NLED] is a
    // constant 0 so that the top segment still has a terminating neighbour.
    logic [NLED:0]   ge;
    logic [NLED-1:0] dot_pat;
    logic [NLED-1:0] bar_pat;
    logic [NLED-1:0] raw_pat;
    logic [NLED-1:0] pattern;

    assign ge[0]    = 1'b1;
    assign ge[NLED] = 1'b0;

    genvar gi;
    for (gi = 1; gi < NLED; gi++) begin : g_thresh
        localparam logic [WIDTH-1:0] TH = WIDTH'(gi * ROM_DEPTH / NLED);
        assign ge[gi] = (pc_q_reg >= TH);
    end

    // Segment k lights LED NLED-1-k: dot keeps only segment i, bar keeps 0..i
    for (gi = 0; gi < NLED; gi++) begin : g_pattern
        assign dot_pat[gi] = ge[NLED-1-gi] & ~ge[NLED-gi];
        assign bar_pat[gi] = ge[NLED-1-gi];
    end

    assign raw_pat = NLED'(pc_q_reg);

    // Display mode select
    always_comb begin
        pattern = '0;
        case (mode)
            MODE_DOT: pattern = dot_pat;
            MODE_BAR: pattern = bar_pat;
            MODE_RAW: pattern = raw_pat;
            default:  pattern = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Halt blink and LED drive
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic               phase_reg, phase_next;
    logic [NLED-1:0]    led_reg, led_next;

    // Free-running blink timebase; LEDs are gated off during the low phase
    // only while halted.
    always_comb begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
        phase_next     = phase_reg;
        if (blink_cnt_reg == BLINK_MAX_C) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end
        led_next = pattern & {NLED{~halted_reg | phase_reg}};
    end

    // Blink timebase and LED output registers
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            led_reg       <= '0;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            led_reg       <= led_next;
        end
    end

    assign clk_core  = clk_core_reg;
    assign core_tick = core_tick_reg;
    assign halted    = halted_reg;
    assign led       = led_reg;

endmodule
